// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock, key schedule run in reverse
// (right rotations), valid/ready handshakes on the ciphertext input and plaintext output.

module des_sbox #(
    parameter logic [255:0] TBL = '0
) (
    input  logic [5:0] sin_i,
    output logic [3:0] sout_o
);
    // Row is outer bits {6,1}, column inner bits 5..2; entry 0 sits in the top nibble.
    logic [5:0] idx;
    assign idx    = {sin_i[5], sin_i[0], sin_i[4:1]};
    assign sout_o = TBL[{~idx, 2'b00} +: 4];
endmodule

module des_decrypt_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ciphertext,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plaintext
);
    localparam int unsigned NROUNDS = 16;

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Tables list source DES bit numbers; DES bit k lives at vector bit (width - k).
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 64; n++) y[6'(63 - n)] = x[6'(64 - IP_T[6'(n)])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 64; n++) y[6'(63 - n)] = x[6'(64 - FP_T[6'(n)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int n = 0; n < 48; n++) y[6'(47 - n)] = x[5'(32 - E_T[6'(n)])];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int n = 0; n < 32; n++) y[5'(31 - n)] = x[5'(32 - P_T[5'(n)])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int n = 0; n < 56; n++) y[6'(55 - n)] = x[6'(64 - PC1_T[6'(n)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int n = 0; n < 48; n++) y[6'(47 - n)] = x[6'(56 - PC2_T[6'(n)])];
        return y;
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, dk_q, dk_d;
    logic [63:0] pt_q, pt_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;

    logic [27:0] c_rot, d_rot;
    logic [47:0] rkey, sx;
    logic [31:0] sbo, f_out;

    // Reverse schedule: no rotation in round 1, one in rounds 2/9/16, two elsewhere.
    always_comb begin
        c_rot = c_q;
        d_rot = dk_q;
        if (cnt_q == 5'd2 || cnt_q == 5'd9 || cnt_q == 5'(NROUNDS)) begin
            c_rot = {c_q[0], c_q[27:1]};
            d_rot = {dk_q[0], dk_q[27:1]};
        end else if (cnt_q != 5'd1) begin
            c_rot = {c_q[1:0], c_q[27:2]};
            d_rot = {dk_q[1:0], dk_q[27:2]};
        end
    end

    assign rkey = perm_pc2({c_rot, d_rot});
    assign sx   = perm_e(r_q) ^ rkey;

    for (genvar j = 0; j < 8; j++) begin : g_sbox
        des_sbox #(.TBL(SBOX[j])) u_sbox (
            .sin_i  (sx[47 - 6*j -: 6]),
            .sout_o (sbo[31 - 4*j -: 4])
        );
    end

    assign f_out = perm_p(sbo);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        dk_d        = dk_q;
        pt_d        = pt_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    {l_d, r_d} = perm_ip(ciphertext);
                    {c_d, dk_d} = perm_pc1(key);
                    cnt_d      = 5'd1;
                    state_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                c_d   = c_rot;
                dk_d  = d_rot;
                cnt_d = 5'(cnt_q + 5'd1);
                if (cnt_q == 5'(NROUNDS)) begin
                    pt_d        = perm_fp({l_q ^ f_out, r_q});
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            dk_q        <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            dk_q        <= dk_d;
            pt_q        <= pt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign plaintext = pt_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed-vector bench for des_decrypt_core: known-answer vectors, latency, back-pressure,
// back-to-back throughput and mid-round reset.

module tb_des_decrypt_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] ciphertext = '0;
    logic [63:0] key = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] plaintext;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam logic [63:0] K_STD = 64'h133457799BBCDFF1;
    localparam logic [63:0] C_STD = 64'h85E813540F0AB405;
    localparam logic [63:0] P_STD = 64'h0123456789ABCDEF;
    localparam logic [63:0] K_V2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P_V2  = 64'h8787878787878787;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    des_decrypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) check({tag, " ready_timeout"}, 64'(in_ready), 64'd1);
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid !== 1'b1) check({tag, " valid_timeout"}, 64'(out_valid), 64'd1);
    endtask

    // One block: accept, check latency and result, optional output stall, then handshake.
    task automatic run_block(input string tag, input logic [63:0] k, input logic [63:0] ct,
                             input logic [63:0] exp, input int hold);
        int acc;
        wait_ready(tag);
        key        = k;
        ciphertext = ct;
        in_valid   = 1'b1;
        out_ready  = (hold == 0);
        @(posedge clk); #1;
        acc      = cyc;
        in_valid = 1'b0;
        check({tag, " in_ready_busy"}, 64'(in_ready), 64'd0);
        wait_out(tag);
        check({tag, " latency"}, 64'(cyc - acc), 64'd16);
        check({tag, " plaintext"}, plaintext, exp);
        check({tag, " in_ready_done"}, 64'(in_ready), 64'd0);
        if (hold > 0) begin
            key        = ~k;
            ciphertext = 64'hDEADBEEFCAFEF00D;
            in_valid   = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, " hold_pt"}, plaintext, exp);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, " valid_cleared"}, 64'(out_valid), 64'd0);
        check({tag, " ready_back"}, 64'(in_ready), 64'd1);
        check({tag, " pt_kept"}, plaintext, exp);
    endtask

    initial begin
        int a1;
        int a2;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset plaintext", plaintext, 64'd0);
        rst_n = 1'b1;

        run_block("std", K_STD, C_STD, P_STD, 0);
        run_block("v2", K_V2, 64'h0, P_V2, 0);
        run_block("v2_parity", K_V2 ^ 64'h0101010101010101, 64'h0, P_V2, 0);
        run_block("weak_stall", 64'h0101010101010101, 64'h8000000000000000,
                  64'h95F8A5E5DD31D900, 10);
        run_block("zero_key", 64'h0101010101010101, 64'h8CA64DE9C1B123A7, 64'h0, 0);
        run_block("var_key", 64'h8001010101010101, 64'h95A8D72813DAA94D, 64'h0, 0);

        // Back-to-back with in_valid held high throughout
        wait_ready("b2b");
        key        = K_STD;
        ciphertext = C_STD;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        a1         = cyc;
        key        = K_V2;
        ciphertext = 64'h0;
        wait_out("b2b first");
        check("b2b first pt", plaintext, P_STD);
        @(posedge clk); #1;
        wait_ready("b2b");
        @(posedge clk); #1;
        a2       = cyc;
        in_valid = 1'b0;
        check("b2b period", 64'(a2 - a1), 64'd18);
        wait_out("b2b second");
        check("b2b second pt", plaintext, P_V2);
        @(posedge clk); #1;

        // Reset pulse at round 7 aborts the block
        wait_ready("rst_mid");
        key        = K_STD;
        ciphertext = C_STD;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid out_valid", 64'(out_valid), 64'd0);
        check("rst_mid plaintext", plaintext, 64'd0);
        check("rst_mid in_ready", 64'(in_ready), 64'd1);
        run_block("after_rst", K_STD, C_STD, P_STD, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
